// File: rtl/alias_field_packer.sv
// Collects fields A, B and C one beat at a time and packs them MSB-first as {A, B, C}.
// The packed word is held in a registered valid/ready output, and out_dup presents it twice.
module alias_field_packer #(
  parameter int A_W   = 9,
  parameter int B_W   = 4,
  parameter int C_W   = 1,
  parameter int CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [A_W-1:0]                 in_data,
  input  logic                           in_abort,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [A_W+B_W+C_W-1:0]         out_word,
  output logic [2*(A_W+B_W+C_W)-1:0]     out_dup,
  output logic [CNT_W-1:0]               word_count,
  output logic [1:0]                     fld_sel
);

  localparam int W = A_W + B_W + C_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    FLD_A = 2'd0,
    FLD_B = 2'd1,
    FLD_C = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [A_W-1:0]   r_a;
  logic [B_W-1:0]   r_b;
  logic             r_out_valid;
  logic [W-1:0]     r_out_word;
  logic [CNT_W-1:0] r_cnt;

  logic w_in_ready;
  logic w_beat;
  logic w_handoff;
  logic w_load_a;
  logic w_load_b;
  logic w_load_out;

  // The field stage stalls only when it holds C and the output slot cannot take a new word.
  assign w_in_ready = (r_state != FLD_C) | ~r_out_valid | out_ready;
  assign w_beat     = in_valid & w_in_ready & ~in_abort;
  assign w_handoff  = r_out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FLD_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_a    = 1'b0;
    w_load_b    = 1'b0;
    w_load_out  = 1'b0;
    if (in_abort) begin
      w_state_nxt = FLD_A;
    end else if (w_beat) begin
      case (r_state)
        FLD_A: begin
          w_load_a    = 1'b1;
          w_state_nxt = FLD_B;
        end
        FLD_B: begin
          w_load_b    = 1'b1;
          w_state_nxt = FLD_C;
        end
        FLD_C: begin
          w_load_out  = 1'b1;
          w_state_nxt = FLD_A;
        end
        default: begin
          w_state_nxt = FLD_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (w_load_a) begin
        r_a <= in_data;
      end
      if (w_load_b) begin
        r_b <= in_data[B_W-1:0];
      end
    end
  end

  // A reload in the handoff cycle wins, so the slot stays full with the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
    end else if (w_load_out) begin
      r_out_valid <= 1'b1;
      r_out_word  <= {r_a, r_b, in_data[C_W-1:0]};
    end else if (w_handoff) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_handoff && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_word   = r_out_word;
  assign out_dup    = {r_out_word, r_out_word};
  assign word_count = r_cnt;
  assign fld_sel    = r_state;

endmodule

// File: tb/tb_alias_field_packer.sv
// Bench for alias_field_packer: directed scenarios plus randomized traffic against a field-level model.
module tb_alias_field_packer;

  localparam int A_W   = 9;
  localparam int B_W   = 4;
  localparam int C_W   = 1;
  localparam int CNT_W = 16;
  localparam int W     = A_W + B_W + C_W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [A_W-1:0]     in_data = '0;
  logic               in_abort = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [W-1:0]       out_word;
  logic [2*W-1:0]     out_dup;
  logic [CNT_W-1:0]   word_count;
  logic [1:0]         fld_sel;

  logic               s_in_valid = 1'b0;
  logic               s_in_ready;
  logic [A_W-1:0]     s_in_data = '0;
  logic               s_out_valid;
  logic [W-1:0]       s_out_word;
  logic [2*W-1:0]     s_out_dup;
  logic [1:0]         s_word_count;
  logic [1:0]         s_fld_sel;

  int n_vec = 0;
  int n_err = 0;

  // Field-level model: which field is next, captured fields, output slot, handed-off count.
  int     m_fld;
  int     m_a;
  int     m_b;
  logic   m_ov;
  longint m_word;
  int     m_cnt;

  alias_field_packer #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_abort(in_abort), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .out_dup(out_dup),
    .word_count(word_count), .fld_sel(fld_sel)
  );

  alias_field_packer #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_abort(1'b0), .out_valid(s_out_valid),
    .out_ready(1'b1), .out_word(s_out_word), .out_dup(s_out_dup),
    .word_count(s_word_count), .fld_sel(s_fld_sel)
  );

  always #5 clk = ~clk;

  function automatic logic model_ready();
    return (m_fld != 2) || !m_ov || out_ready;
  endfunction

  function automatic longint model_dup();
    return (m_word << W) | m_word;
  endfunction

  task automatic model_reset();
    m_fld  = 0;
    m_a    = 0;
    m_b    = 0;
    m_ov   = 1'b0;
    m_word = 0;
    m_cnt  = 0;
  endtask

  task automatic model_step();
    logic acc;
    acc = in_valid && model_ready() && !in_abort;
    if (m_ov && out_ready) begin
      if (m_cnt < CMAX) m_cnt++;
      m_ov = 1'b0;
    end
    if (in_abort) begin
      m_fld = 0;
    end else if (acc) begin
      if (m_fld == 0) begin
        m_a = int'(in_data);
        m_fld = 1;
      end else if (m_fld == 1) begin
        m_b = int'(in_data) % (1 << B_W);
        m_fld = 2;
      end else begin
        m_word = (longint'(m_a) << (B_W + C_W)) | (longint'(m_b) << C_W)
               | longint'(int'(in_data) % (1 << C_W));
        m_ov = 1'b1;
        m_fld = 0;
      end
    end
  endtask

  task automatic drive(input logic v, input int d, input logic ab, input logic ord);
    @(negedge clk);
    in_valid  = v;
    in_data   = d[A_W-1:0];
    in_abort  = ab;
    out_ready = ord;
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_word !== '0 || out_dup !== '0 || word_count !== '0 || fld_sel !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: valid=%0b word=%h dup=%h cnt=%0d fld=%0d, required all zero",
               out_valid, out_word, out_dup, word_count, fld_sel);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    drive(1, 'h1A5, 0, 1); tick();
    drive(1, 'hC, 0, 1);   tick();
    drive(1, 'h1, 0, 1);
    n_vec++;
    if (out_valid !== 1'b0 || fld_sel !== 2'd2) begin
      n_err++;
      $display("FAIL basic_pre: valid=%0b fld=%0d, required 0 and 2", out_valid, fld_sel);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_word !== 14'h34B9 || out_dup !== 28'hD2E74B9) begin
      n_err++;
      $display("FAIL basic_word: valid=%0b word=%h dup=%h, required 1 34b9 d2e74b9",
               out_valid, out_word, out_dup);
    end
    drive(0, 0, 0, 1); tick();
    n_vec++;
    if (word_count !== 16'd1 || out_valid !== 1'b0 || out_word !== 14'h34B9) begin
      n_err++;
      $display("FAIL basic_handoff: cnt=%0d valid=%0b word=%h, required 1 0 34b9",
               word_count, out_valid, out_word);
    end
  endtask

  task automatic test_stall();
    drive(1, 'h1A5, 0, 0); tick();
    drive(1, 'hC, 0, 0);   tick();
    drive(1, 'h1, 0, 0);   tick();
    drive(1, 'h000, 0, 0); tick();
    drive(1, 'h3, 0, 0);   tick();
    drive(1, 'h0, 0, 0);
    n_vec++;
    if (in_ready !== 1'b0 || fld_sel !== 2'd2 || out_word !== 14'h34B9) begin
      n_err++;
      $display("FAIL stall_hold: ready=%0b fld=%0d word=%h, required 0 2 34b9", in_ready, fld_sel, out_word);
    end
    tick();
    drive(1, 'h0, 0, 1);
    n_vec++;
    if (in_ready !== 1'b1 || out_word !== 14'h34B9 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release: ready=%0b word=%h valid=%0b, required 1 34b9 1", in_ready, out_word, out_valid);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_word !== 14'h0006 || word_count !== 16'd2 || fld_sel !== 2'd0) begin
      n_err++;
      $display("FAIL stall_reload: valid=%0b word=%h cnt=%0d fld=%0d, required 1 0006 2 0",
               out_valid, out_word, word_count, fld_sel);
    end
    drive(0, 0, 0, 1); tick();
  endtask

  task automatic test_abort();
    drive(1, 'h0FF, 0, 1); tick();
    drive(1, 'h1, 0, 1);   tick();
    drive(1, 'h1, 1, 1);   tick();
    n_vec++;
    if (fld_sel !== 2'd0 || out_valid !== 1'b0 || out_word !== 14'h0006) begin
      n_err++;
      $display("FAIL abort_state: fld=%0d valid=%0b word=%h, required 0 0 0006", fld_sel, out_valid, out_word);
    end
    drive(1, 'h001, 0, 1); tick();
    drive(1, 'h2, 0, 1);   tick();
    drive(1, 'h1, 0, 1);   tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_word !== 14'h0025) begin
      n_err++;
      $display("FAIL abort_next: valid=%0b word=%h, required 1 0025", out_valid, out_word);
    end
  endtask

  task automatic test_upper_bits();
    drive(1, 'h100, 0, 1); tick();
    drive(1, 'h1FF, 0, 1); tick();
    drive(1, 'h1FF, 0, 1); tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_word !== 14'h201F || out_dup !== {14'h201F, 14'h201F}) begin
      n_err++;
      $display("FAIL upper_bits: valid=%0b word=%h dup=%h, required 1 201f", out_valid, out_word, out_dup);
    end
    drive(0, 0, 0, 1); tick();
  endtask

  task automatic test_reset_midword();
    drive(1, 'h055, 0, 0); tick();
    drive(1, 'h5, 0, 0);   tick();
    drive(1, 'h0, 0, 0);   tick();
    drive(1, 'h0AA, 0, 0); tick();
    n_vec++;
    if (out_valid !== 1'b1 || fld_sel !== 2'd1 || word_count === '0) begin
      n_err++;
      $display("FAIL rst_setup: valid=%0b fld=%0d cnt=%0d, required 1 1 nonzero", out_valid, fld_sel, word_count);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_word !== '0 || out_dup !== '0 || word_count !== '0 || fld_sel !== 2'd0) begin
      n_err++;
      $display("FAIL rst_async: valid=%0b word=%h dup=%h cnt=%0d fld=%0d, required all zero",
               out_valid, out_word, out_dup, word_count, fld_sel);
    end
    model_reset();
    drive(0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_saturate();
    int exp_cnt;
    for (int w = 0; w < 5; w++) begin
      for (int f = 0; f < 3; f++) begin
        @(negedge clk);
        s_in_valid = 1'b1;
        s_in_data  = A_W'(w * 3 + f + 1);
        @(posedge clk);
        #1;
        if (f == 0) begin
          exp_cnt = (w < 3) ? w : 3;
          n_vec++;
          if (int'(s_word_count) !== exp_cnt) begin
            n_err++;
            $display("FAIL sat_count_w%0d: got %0d required %0d", w, s_word_count, exp_cnt);
          end
        end
      end
    end
    @(negedge clk);
    s_in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (s_word_count !== 2'd3 || s_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sat_final: cnt=%0d valid=%0b, required 3 0", s_word_count, s_out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, int'($urandom), ($urandom % 12) == 0, ($urandom % 2) == 1);
      n_vec++;
      if (in_ready !== model_ready() || out_valid !== m_ov || out_word !== W'(m_word)
          || out_dup !== (2*W)'(model_dup()) || word_count !== CNT_W'(m_cnt) || fld_sel !== 2'(m_fld)) begin
        n_err++;
        $display("FAIL random_%0d: rdy=%0b ov=%0b word=%h cnt=%0d fld=%0d, required rdy=%0b ov=%0b word=%h cnt=%0d fld=%0d",
                 i, in_ready, out_valid, out_word, word_count, fld_sel,
                 model_ready(), m_ov, m_word, m_cnt, m_fld);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_abort();
    test_upper_bits();
    test_reset_midword();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
